lsu_ctrl: RTL and testbench

//  Sequencer between the pipeline MEM stage and a single-port, word-wide data memory.

---
 rtl/lsu_ctrl_pkg.sv | 68 ++++++
 rtl/lsu_lane.sv | 58 +++++
 rtl/lsu_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - shared funct3 codes, FSM states and access-size decode for the LSU
//
// Purpose: common types and decode helpers used by lsu_ctrl and lsu_lane.
// Ports:   none (package).

package lsu_ctrl_pkg;

    localparam logic [2:0] F3_LD       = 3'b011;
    localparam logic [2:0] F3_LWU      = 3'b110;
    localparam logic [2:0] F3_LOAD_BAD = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } lsu_state_e;

    // funct3[1:0] encodes the access size for both loads and stores.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    function automatic lsu_size_e size_of(input logic [2:0] funct3);
        return lsu_size_e'(funct3[1:0]);
    endfunction

    // Encodings with no meaning for this XLEN are rejected before any memory access.
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3,
                                        input logic is64);
        logic bad;
        if (we) begin
            bad = funct3[2] || (!is64 && (funct3[1:0] == 2'b11));
        end else begin
            bad = (funct3 == F3_LOAD_BAD) ||
                  (!is64 && ((funct3 == F3_LD) || (funct3 == F3_LWU)));
        end
        return bad;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] low);
        logic bad;
        case (size_of(funct3))
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = low[0];
            SZ_W:    bad = |low[1:0];
            default: bad = |low;
        endcase
        return bad;
    endfunction

    // Byte-lane mask for an access of the given size at offset 0.
    function automatic logic [7:0] lane_mask(input lsu_size_e sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte-lane extract/extend for loads and lane merge for sub-word stores
//
// Purpose: pure combinational lane logic.
// Ports:
//   off        in   ALIGN_W  byte offset within the word
//   funct3     in   3        access funct3 (size in [1:0], unsigned-load flag in [2])
//   word       in   XLEN     word read from memory
//   wdata      in   XLEN     right-justified store data
//   load_data  out  XLEN     selected lane, sign- or zero-extended
//   store_word out  XLEN     word with the addressed lanes replaced by wdata

module lsu_lane
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALIGN_W = 2
) (
    input  logic [ALIGN_W-1:0] off,
    input  logic [2:0]         funct3,
    input  logic [XLEN-1:0]    word,
    input  logic [XLEN-1:0]    wdata,
    output logic [XLEN-1:0]    load_data,
    output logic [XLEN-1:0]    store_word
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] word_sh;
    logic [XLEN-1:0] wdata_sh;
    logic [7:0]      mask8;
    logic [NB-1:0]   bmask;

    always_comb begin
        // Bring the addressed lane down to bit 0 before extension.
        word_sh = word >> {off, 3'b000};
        case (size_of(funct3))
            SZ_B:    load_data = funct3[2] ? XLEN'(word_sh[7:0])
                                           : XLEN'($signed(word_sh[7:0]));
            SZ_H:    load_data = funct3[2] ? XLEN'(word_sh[15:0])
                                           : XLEN'($signed(word_sh[15:0]));
            SZ_W:    load_data = funct3[2] ? XLEN'(word_sh[31:0])
                                           : XLEN'($signed(word_sh[31:0]));
            default: load_data = word_sh;
        endcase

        // Only bytes inside the access are taken from wdata; the rest pass through.
        mask8    = lane_mask(size_of(funct3)) << off;
        bmask    = NB'(mask8);
        wdata_sh = wdata << {off, 3'b000};
        store_word = word;
        for (int i = 0; i < NB; i++) begin
            if (bmask[i]) begin
                store_word[8*i +: 8] = wdata_sh[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between the MEM stage and a word-wide memory
//
// Purpose: accepts one access per handshake, checks it, runs read / read-modify-write /
//          write sequences on the memory port and returns a one-cycle response.
// Ports:
//   clock, reset_n               clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake (ready only while idle)
//   req_we, req_funct3           store flag and RV funct3
//   req_addr, req_wdata          byte address, right-justified store data
//   rsp_valid, rsp_rdata, rsp_err  one-cycle response pulse, load data, error flag
//   mem_req, mem_we, mem_addr, mem_wdata  level-held memory request
//   mem_gnt, mem_rvalid, mem_rdata        memory grant and read return

module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALIGN_W = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic      IS64    = (XLEN == 64);
    localparam lsu_size_e FULL_SZ = IS64 ? SZ_D : SZ_W;

    lsu_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

    logic            accept;
    logic [XLEN-1:0] lane_load;
    logic [XLEN-1:0] lane_store;

    lsu_lane #(
        .XLEN    (XLEN),
        .ALIGN_W (ALIGN_W)
    ) u_lane (
        .off        (addr_q[ALIGN_W-1:0]),
        .funct3     (funct3_q),
        .word       (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (lane_load),
        .store_word (lane_store)
    );

    assign accept = req_valid && req_ready_q;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    result_d = '0;
                    err_d    = is_illegal(req_we, req_funct3, IS64) ||
                               is_misaligned(req_funct3, req_addr[2:0]);
                    if (err_d) begin
                        state_d = ST_RESP;
                    end else if (req_we && (size_of(req_funct3) == FULL_SZ)) begin
                        state_d = ST_WR;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (mem_gnt) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rvalid) begin
                    if (we_q) begin
                        state_d = ST_WR;
                    end else begin
                        result_d = lane_load;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_WR: begin
                if (mem_gnt) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs follow the current state, so ready returns only after the
        // response cycle has been fully presented.
        req_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
        rsp_valid_d = (state_q == ST_RESP);
        rsp_err_d   = rsp_valid_d && err_q;
        rsp_rdata_d = rsp_valid_d ? result_q : '0;

        // Memory outputs follow the next state so a request launches on the entry edge.
        mem_req_d  = (state_d == ST_RD) || (state_d == ST_WR);
        mem_we_d   = (state_d == ST_WR);
        mem_addr_d = mem_req_d ? {addr_d[XLEN-1:ALIGN_W], {ALIGN_W{1'b0}}} : '0;

        mem_wdata_d = '0;
        if (state_d == ST_WR) begin
            case (state_q)
                ST_IDLE:    mem_wdata_d = req_wdata;
                ST_RD_WAIT: mem_wdata_d = lane_store;
                default:    mem_wdata_d = mem_wdata_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            result_q    <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            result_q    <= result_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl

module tb_lsu_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_word = '0;

    int          total = 0;
    int          bad = 0;
    int          grants = 0;
    int          reads = 0;
    int          writes = 0;
    logic [31:0] rd_addr = '0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    bit          rd_fire = 1'b0;
    bit          gnt_en = 1'b1;

    lsu_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_word)
    );

    always #5 clock = ~clock;

    // Memory: grants in the same cycle as the request, read data the cycle after the grant.
    always @(negedge clock) begin
        mem_gnt    = mem_req && gnt_en;
        mem_rvalid = rd_fire;
        rd_fire    = 1'b0;
    end

    always @(posedge clock) begin
        if (reset_n && mem_req && mem_gnt) begin
            grants++;
            if (mem_we) begin
                writes++;
                wr_addr = mem_addr;
                wr_data = mem_wdata;
            end else begin
                reads++;
                rd_addr = mem_addr;
                rd_fire = 1'b1;
            end
        end
    end

    task automatic clear_counts();
        grants = 0;
        reads  = 0;
        writes = 0;
    endtask

    // Latency = number of rising edges from the accept edge to the edge that samples rsp_valid.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er, output logic one_shot);
        int guard;
        lat = -1;
        rd = 32'hxxxxxxxx;
        er = 1'bx;
        one_shot = 1'b0;
        @(negedge clock);
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (rsp_valid) begin
                lat = k;
                rd = rsp_rdata;
                er = rsp_err;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        one_shot = (lat > 0) && !rsp_valid;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if ({req_ready, rsp_valid, rsp_err, mem_req, mem_we} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {req_ready, rsp_valid, rsp_err, mem_req, mem_we});
        end
        total++;
        if ({mem_addr, mem_wdata, rsp_rdata} !== 96'b0) begin
            bad++;
            $display("FAIL reset_bus got=%h exp=0", {mem_addr, mem_wdata, rsp_rdata});
        end
        reset_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge got=%b exp=0", req_ready);
        end
        @(negedge clock);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_release got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_load_word();
        int lat;
        logic [31:0] rd;
        logic er, os;
        mem_word = 32'hDEADBEEF;
        clear_counts();
        do_req(1'b0, 3'b010, 32'h100, 32'h0, lat, rd, er, os);
        total++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            bad++;
            $display("FAIL lw_data got=%h err=%b exp=deadbeef err=0", rd, er);
        end
        total++;
        if (rd_addr !== 32'h100 || reads != 1 || writes != 0) begin
            bad++;
            $display("FAIL lw_mem got addr=%h rd=%0d wr=%0d exp addr=100 rd=1 wr=0",
                     rd_addr, reads, writes);
        end
        total++;
        if (lat != 4) begin
            bad++;
            $display("FAIL lw_latency got=%0d exp=4", lat);
        end
        total++;
        if (os !== 1'b1) begin
            bad++;
            $display("FAIL lw_pulse got=%b exp=1", os);
        end
    endtask

    task automatic test_load_sub();
        logic [2:0]  f3s  [6];
        logic [31:0] adrs [6];
        logic [31:0] exps [6];
        int lat;
        logic [31:0] rd;
        logic er, os;
        f3s  = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b100};
        adrs = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h102, 32'h100};
        exps = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFFF, 32'hFFFF80FF,
                 32'h000080FF, 32'h00000000};
        mem_word = 32'h80FF0000;
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, f3s[i], adrs[i], 32'h0, lat, rd, er, os);
            total++;
            if (rd !== exps[i] || er !== 1'b0 || lat != 4) begin
                bad++;
                $display("FAIL load_sub%0d got=%h err=%b lat=%0d exp=%h err=0 lat=4",
                         i, rd, er, lat, exps[i]);
            end
        end
    endtask

    task automatic test_store_sub();
        logic [2:0]  f3s  [4];
        logic [31:0] adrs [4];
        logic [31:0] wds  [4];
        logic [31:0] exps [4];
        int lat;
        logic [31:0] rd;
        logic er, os;
        f3s  = '{3'b000, 3'b001, 3'b000, 3'b001};
        adrs = '{32'h102, 32'h102, 32'h101, 32'h100};
        wds  = '{32'h555555AA, 32'h1234BEEF, 32'h00000077, 32'h0000BEEF};
        exps = '{32'h11AA3344, 32'hBEEF3344, 32'h11227744, 32'h1122BEEF};
        mem_word = 32'h11223344;
        for (int i = 0; i < 4; i++) begin
            clear_counts();
            do_req(1'b1, f3s[i], adrs[i], wds[i], lat, rd, er, os);
            total++;
            if (wr_data !== exps[i] || wr_addr !== 32'h100) begin
                bad++;
                $display("FAIL store_sub%0d got=%h@%h exp=%h@00000100",
                         i, wr_data, wr_addr, exps[i]);
            end
            total++;
            if (grants != 2 || reads != 1 || lat != 5 || rd !== 32'h0 || er !== 1'b0) begin
                bad++;
                $display("FAIL store_sub%0d_seq got gnt=%0d rd=%0d lat=%0d data=%h err=%b exp gnt=2 rd=1 lat=5 data=0 err=0",
                         i, grants, reads, lat, rd, er);
            end
        end
    endtask

    task automatic test_store_word();
        int lat;
        logic [31:0] rd;
        logic er, os;
        mem_word = 32'h0;
        clear_counts();
        do_req(1'b1, 3'b010, 32'h200, 32'hCAFEF00D, lat, rd, er, os);
        total++;
        if (wr_data !== 32'hCAFEF00D || wr_addr !== 32'h200) begin
            bad++;
            $display("FAIL sw_write got=%h@%h exp=cafef00d@00000200", wr_data, wr_addr);
        end
        total++;
        if (grants != 1 || reads != 0 || lat != 3 || er !== 1'b0) begin
            bad++;
            $display("FAIL sw_seq got gnt=%0d rd=%0d lat=%0d err=%b exp gnt=1 rd=0 lat=3 err=0",
                     grants, reads, lat, er);
        end
    endtask

    task automatic test_errors();
        logic        wes  [8];
        logic [2:0]  f3s  [8];
        logic [31:0] adrs [8];
        int lat;
        logic [31:0] rd;
        logic er, os;
        // LH misaligned, LW misaligned, load 111, store 1xx, LD, SD, LWU, SH misaligned
        wes  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        f3s  = '{3'b001, 3'b010, 3'b111, 3'b100, 3'b011, 3'b011, 3'b110, 3'b001};
        adrs = '{32'h101, 32'h102, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h103};
        mem_word = 32'h5A5A5A5A;
        for (int i = 0; i < 8; i++) begin
            clear_counts();
            do_req(wes[i], f3s[i], adrs[i], 32'hFFFFFFFF, lat, rd, er, os);
            total++;
            if (er !== 1'b1 || rd !== 32'h0 || grants != 0 || lat != 2) begin
                bad++;
                $display("FAIL err%0d got err=%b data=%h gnt=%0d lat=%0d exp err=1 data=0 gnt=0 lat=2",
                         i, er, rd, grants, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int pulses;
        pulses = 0;
        @(negedge clock);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = 3'b001;
        req_addr = 32'h101;
        for (int i = 0; i < 12; i++) begin
            if (req_ready && req_valid) acc.push_back(i);
            if (rsp_valid) pulses++;
            @(negedge clock);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clock);
        total++;
        if (acc.size() < 3) begin
            bad++;
            $display("FAIL b2b_accepts got=%0d exp>=3", acc.size());
        end else begin
            total++;
            if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
                bad++;
                $display("FAIL b2b_spacing got=%0d,%0d exp=3,3",
                         acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
        total++;
        if (pulses < 3) begin
            bad++;
            $display("FAIL b2b_pulses got=%0d exp>=3", pulses);
        end
    endtask

    task automatic test_wr_stall_reset();
        int guard;
        int stray;
        gnt_en = 1'b0;
        clear_counts();
        @(negedge clock);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h300;
        req_wdata = 32'hDEADBEEF;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h300, 32'hDEADBEEF}) begin
                bad++;
                $display("FAIL stall%0d got req=%b we=%b addr=%h data=%h exp 1 1 00000300 deadbeef",
                         i, mem_req, mem_we, mem_addr, mem_wdata);
            end
            @(negedge clock);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_err, mem_req, mem_we} !== 5'b0 ||
            {mem_addr, mem_wdata, rsp_rdata} !== 96'b0) begin
            bad++;
            $display("FAIL stall_reset got ctl=%b addr=%h data=%h rdata=%h exp all 0",
                     {req_ready, rsp_valid, rsp_err, mem_req, mem_we}, mem_addr, mem_wdata,
                     rsp_rdata);
        end
        @(negedge clock);
        reset_n = 1'b1;
        gnt_en = 1'b1;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (rsp_valid || mem_req) stray++;
        end
        total++;
        if (stray != 0 || grants != 0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset got stray=%0d gnt=%0d ready=%b exp 0 0 1",
                     stray, grants, req_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_word();
        test_load_sub();
        test_store_sub();
        test_store_word();
        test_errors();
        test_back_to_back();
        test_wr_stall_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
